dual_issue_dispatch: RTL and testbench

DUAL_ISSUE_DISPATCH -- requirements
Module: dual_issue_dispatch

---
 rtl/dual_issue_dispatch.sv | 162 ++++++++++++++++
 tb/tb_dual_issue_dispatch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_dispatch.sv
// ============================================================================
// Module   : dual_issue_dispatch
// Brief    : Instruction queue that issues one or two words per cycle into an
//            ALU/branch slot (A) and an ALU/memory slot (B).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_issue_dispatch #(
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid0,
  input  logic        fetch_valid1,
  input  logic [31:0] fetch_inst0,
  input  logic [31:0] fetch_inst1,
  output logic        fetch_ready,
  input  logic        issue_stall,
  input  logic        flush,
  output logic [31:0] inst_a,
  output logic [31:0] inst_b,
  output logic        valid_a,
  output logic        valid_b,
  output logic        a_is_older
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(QDEPTH - 2);
  localparam logic [1:0] C_ALU = 2'd0;
  localparam logic [1:0] C_BR  = 2'd1;
  localparam logic [1:0] C_MEM = 2'd2;
  localparam logic [1:0] C_OTH = 2'd3;

  function automatic logic [1:0] f_class(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011: f_class = C_ALU;
      7'b1100111:             f_class = C_BR;
      7'b0000011, 7'b0100011: f_class = C_MEM;
      default:                f_class = C_OTH;
    endcase
  endfunction

  function automatic logic f_writes(input logic [6:0] op);
    f_writes = (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011);
  endfunction

  function automatic logic f_reads2(input logic [6:0] op);
    f_reads2 = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100111);
  endfunction

  logic [31:0]   mem_q [QDEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   inst_a_q, inst_b_q, inst_a_d, inst_b_d;
  logic          valid_a_q, valid_b_q, valid_a_d, valid_b_d;
  logic          older_q, older_d;

  logic          w_push;
  logic [CW-1:0] w_push_n, w_issue_n, w_pop_n;
  logic [31:0]   w_i0, w_i1;
  logic [1:0]    w_c0, w_c1;
  logic          w_have0, w_have1;
  logic          w_straight, w_swap, w_raw, w_waw, w_pair;

  assign fetch_ready = (count_q <= READY_MAX);
  assign w_push      = fetch_ready && fetch_valid0 && !flush && !rst;
  assign w_push_n    = w_push ? (fetch_valid1 ? CW'(2) : CW'(1)) : '0;
  assign w_pop_n     = issue_stall ? '0 : w_issue_n;
  assign count_d     = count_q - w_pop_n + w_push_n;

  assign w_i0    = mem_q[rd_ptr_q];
  assign w_i1    = mem_q[rd_ptr_q + PW'(1)];
  assign w_have0 = (count_q != '0);
  assign w_have1 = (count_q >= CW'(2));
  assign w_c0    = f_class(w_i0[6:0]);
  assign w_c1    = f_class(w_i1[6:0]);

  // Straight keeps program order in A/B; swap puts the younger word in A.
  assign w_straight = (w_c0 == C_ALU) && ((w_c1 == C_ALU) || (w_c1 == C_MEM));
  assign w_swap     = ((w_c0 == C_ALU) || (w_c0 == C_MEM)) &&
                      ((w_c1 == C_ALU) || (w_c1 == C_BR));
  assign w_raw      = f_writes(w_i0[6:0]) && (w_i0[11:7] != 5'd0) &&
                      ((w_i1[19:15] == w_i0[11:7]) ||
                       (f_reads2(w_i1[6:0]) && (w_i1[24:20] == w_i0[11:7])));
  assign w_waw      = f_writes(w_i0[6:0]) && f_writes(w_i1[6:0]) &&
                      (w_i0[11:7] != 5'd0) && (w_i0[11:7] == w_i1[11:7]);
  assign w_pair     = w_have1 && (w_straight || w_swap) && !w_raw && !w_waw;

  always_comb begin
    inst_a_d  = NOP_INST;
    inst_b_d  = NOP_INST;
    valid_a_d = 1'b0;
    valid_b_d = 1'b0;
    older_d   = 1'b1;
    w_issue_n = '0;
    if (w_pair) begin
      w_issue_n = CW'(2);
      valid_a_d = 1'b1;
      valid_b_d = 1'b1;
      if (w_straight) begin
        inst_a_d = w_i0;
        inst_b_d = w_i1;
      end else begin
        inst_a_d = w_i1;
        inst_b_d = w_i0;
        older_d  = 1'b0;
      end
    end else if (w_have0) begin
      w_issue_n = CW'(1);
      if ((w_c0 == C_ALU) || (w_c0 == C_BR)) begin
        inst_a_d  = w_i0;
        valid_a_d = 1'b1;
      end else begin
        inst_b_d  = w_i0;
        valid_b_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= fetch_inst0;
      if (fetch_valid1) mem_q[wr_ptr_q + PW'(1)] <= fetch_inst1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      inst_a_q  <= NOP_INST;
      inst_b_q  <= NOP_INST;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      older_q   <= 1'b1;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_q + w_push_n[PW-1:0];
      rd_ptr_q <= rd_ptr_q + w_pop_n[PW-1:0];
      if (!issue_stall) begin
        inst_a_q  <= inst_a_d;
        inst_b_q  <= inst_b_d;
        valid_a_q <= valid_a_d;
        valid_b_q <= valid_b_d;
        older_q   <= older_d;
      end
    end
  end

  assign inst_a     = inst_a_q;
  assign inst_b     = inst_b_q;
  assign valid_a    = valid_a_q;
  assign valid_b    = valid_b_q;
  assign a_is_older = older_q;

endmodule

`default_nettype wire

// File: tb/tb_dual_issue_dispatch.sv
// ============================================================================
// Module   : tb_dual_issue_dispatch
// Brief    : Directed and random checking of dual_issue_dispatch against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dual_issue_dispatch;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int          QD  = 4;

  localparam logic [31:0] ADD = 32'h003100B3;
  localparam logic [31:0] LW  = 32'h0002A203;
  localparam logic [31:0] SUB = 32'h40708333;
  localparam logic [31:0] JR  = 32'h00208067;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_valid0 = 1'b0, fetch_valid1 = 1'b0;
  logic [31:0] fetch_inst0 = '0, fetch_inst1 = '0;
  logic        fetch_ready;
  logic        issue_stall = 1'b0, flush = 1'b0;
  logic [31:0] inst_a, inst_b;
  logic        valid_a, valid_b, a_is_older;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mq[$];
  logic [31:0] ea = NOP, eb = NOP;
  logic        eva = 1'b0, evb = 1'b0, eold = 1'b1;

  dual_issue_dispatch #(.NOP_INST(NOP), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid0(fetch_valid0), .fetch_valid1(fetch_valid1),
    .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1),
    .fetch_ready(fetch_ready), .issue_stall(issue_stall), .flush(flush),
    .inst_a(inst_a), .inst_b(inst_b), .valid_a(valid_a), .valid_b(valid_b),
    .a_is_older(a_is_older)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction kinds: 0 ALU, 1 BR, 2 MEM, 3 OTHER.
  function automatic int kind(input logic [31:0] w);
    case (w[6:0])
      7'b0110011, 7'b0010011: return 0;
      7'b1100111:             return 1;
      7'b0000011, 7'b0100011: return 2;
      default:                return 3;
    endcase
  endfunction

  function automatic bit writes_rd(input logic [31:0] w);
    return (w[6:0] == 7'b0110011) || (w[6:0] == 7'b0010011) || (w[6:0] == 7'b0000011);
  endfunction

  function automatic bit uses_rs2(input logic [31:0] w);
    return (w[6:0] == 7'b0110011) || (w[6:0] == 7'b0100011) || (w[6:0] == 7'b1100111);
  endfunction

  function automatic bit fits_a(input int k); return (k == 0) || (k == 1); endfunction
  function automatic bit fits_b(input int k); return (k == 0) || (k == 2); endfunction

  task automatic model_issue();
    logic [31:0] i0, i1;
    bit order_ok, swap_ok, hazard;
    ea = NOP; eb = NOP; eva = 1'b0; evb = 1'b0; eold = 1'b1;
    if (mq.size() == 0) return;
    i0 = mq[0];
    if (mq.size() >= 2 && kind(i0) != 1 && kind(i0) != 3 && kind(mq[1]) != 3) begin
      i1 = mq[1];
      order_ok = fits_a(kind(i0)) && fits_b(kind(i1));
      swap_ok  = fits_b(kind(i0)) && fits_a(kind(i1));
      hazard   = writes_rd(i0) && i0[11:7] != 0 &&
                 (i1[19:15] == i0[11:7] || (uses_rs2(i1) && i1[24:20] == i0[11:7]) ||
                  (writes_rd(i1) && i1[11:7] == i0[11:7]));
      if ((order_ok || swap_ok) && !hazard) begin
        eva = 1'b1; evb = 1'b1;
        if (order_ok) begin ea = i0; eb = i1; end
        else begin ea = i1; eb = i0; eold = 1'b0; end
        void'(mq.pop_front());
        void'(mq.pop_front());
        return;
      end
    end
    if (fits_a(kind(i0))) begin ea = i0; eva = 1'b1; end
    else begin eb = i0; evb = 1'b1; end
    void'(mq.pop_front());
  endtask

  task automatic step(input bit v0, input bit v1, input logic [31:0] w0, input logic [31:0] w1,
                      input bit st, input bit fl, input bit rs);
    bit rdy;
    fetch_valid0 = v0; fetch_valid1 = v0 & v1;
    fetch_inst0 = w0; fetch_inst1 = w1;
    issue_stall = st; flush = fl; rst = rs;
    @(posedge clk);
    if (rs || fl) begin
      mq.delete();
      ea = NOP; eb = NOP; eva = 1'b0; evb = 1'b0; eold = 1'b1;
    end else begin
      rdy = (mq.size() <= QD - 2);
      if (!st) model_issue();
      if (rdy && v0) begin
        mq.push_back(w0);
        if (v1) mq.push_back(w1);
      end
    end
    #1;
    check_eq("inst_a", inst_a, ea);
    check_eq("inst_b", inst_b, eb);
    check_eq("valid_a", {31'd0, valid_a}, {31'd0, eva});
    check_eq("valid_b", {31'd0, valid_b}, {31'd0, evb});
    check_eq("a_is_older", {31'd0, a_is_older}, {31'd0, eold});
    check_eq("fetch_ready", {31'd0, fetch_ready}, {31'd0, (mq.size() <= QD - 2)});
  endtask

  task automatic idle(input bit st);
    step(1'b0, 1'b0, '0, '0, st, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [6] = '{7'b0110011, 7'b0010011, 7'b1100111, 7'b0000011, 7'b0100011, 7'b0110111};
    logic [31:0] w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 5)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_ready", {31'd0, fetch_ready}, 32'd1);
    check_eq("rst_inst_a", inst_a, NOP);
    check_eq("rst_older", {31'd0, a_is_older}, 32'd1);

    // Straight pair add + lw.
    step(1'b1, 1'b1, ADD, LW, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("pair_a", inst_a, ADD);
    check_eq("pair_b", inst_b, LW);
    check_eq("pair_vb", {31'd0, valid_b}, 32'd1);
    check_eq("pair_older", {31'd0, a_is_older}, 32'd1);

    // RAW between add x1 and sub x6,x1,x7.
    step(1'b1, 1'b1, ADD, SUB, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("raw_a1", inst_a, ADD);
    check_eq("raw_vb1", {31'd0, valid_b}, 32'd0);
    check_eq("raw_b1", inst_b, NOP);
    idle(1'b0);
    check_eq("raw_a2", inst_a, SUB);

    // Swapped pair lw then add.
    step(1'b1, 1'b1, LW, ADD, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("swap_a", inst_a, ADD);
    check_eq("swap_b", inst_b, LW);
    check_eq("swap_older", {31'd0, a_is_older}, 32'd0);

    // Two loads, then branch + add.
    step(1'b1, 1'b1, LW, LW, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("lwlw_va", {31'd0, valid_a}, 32'd0);
    idle(1'b0);
    step(1'b1, 1'b1, JR, ADD, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("br_a", inst_a, JR);
    check_eq("br_vb", {31'd0, valid_b}, 32'd0);
    idle(1'b0);
    check_eq("br_then_add", inst_a, ADD);
    idle(1'b0);

    // Fill under stall, then flush while still stalled.
    step(1'b1, 1'b1, ADD, LW, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, SUB, LW, 1'b1, 1'b0, 1'b0);
    check_eq("full_ready", {31'd0, fetch_ready}, 32'd0);
    step(1'b1, 1'b1, ADD, ADD, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, ADD, ADD, 1'b1, 1'b1, 1'b0);
    check_eq("flush_ready", {31'd0, fetch_ready}, 32'd1);
    check_eq("flush_va", {31'd0, valid_a}, 32'd0);

    // Reset with three words queued.
    step(1'b1, 1'b1, ADD, LW, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, SUB, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("rst3_va", {31'd0, valid_a}, 32'd0);
    idle(1'b0);
    check_eq("rst3_stale", {31'd0, valid_a | valid_b}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, rand_inst(), rand_inst(),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
